// File: rtl/lsu_mem_arb.sv
// lsu_mem_arb: round-robin arbiter sharing one memory port between LSU loads and committed stores
// Ports:
//   clk, rst                   clock and synchronous active-high reset
//   ld_req_*                   load request (addr, ROB tag) with ready handshake
//   ld_resp_*                  one-cycle load completion pulse with tag and data
//   st_req_*                   store request (addr, data) with ready handshake
//   mem_req_*                  single outstanding memory request (we, addr, wdata)
//   mem_resp_*                 memory read data return
//   busy                       transaction in progress
//   timeout_err                sticky flag, a read got no response within RD_TIMEOUT cycles
module lsu_mem_arb #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int ROB_W      = 6,
    parameter int RD_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_req_valid,
    output logic              ld_req_ready,
    input  logic [ADDR_W-1:0] ld_req_addr,
    input  logic [ROB_W-1:0]  ld_req_rob,
    output logic              ld_resp_valid,
    output logic [ROB_W-1:0]  ld_resp_rob,
    output logic [DATA_W-1:0] ld_resp_data,
    input  logic              st_req_valid,
    output logic              st_req_ready,
    input  logic [ADDR_W-1:0] st_req_addr,
    input  logic [DATA_W-1:0] st_req_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic              busy,
    output logic              timeout_err
);
    localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, REQ, RD_WAIT} state_t;
    state_t state, state_nxt;
    logic last_st;
    logic [ROB_W-1:0] rob_q;
    logic [CNT_W-1:0] cnt;
    logic grant_st, grant_ld, resp_hit, expired;
    // A same-address conflict always favours the store so the load observes the committed value.
    assign grant_st = st_req_valid && (!ld_req_valid || ld_req_addr == st_req_addr || !last_st);
    assign grant_ld = ld_req_valid && !grant_st;
    assign ld_req_ready = state == IDLE && grant_ld;
    assign st_req_ready = state == IDLE && grant_st;
    assign mem_req_valid = state == REQ;
    assign busy = state != IDLE;
    assign resp_hit = state == RD_WAIT && mem_resp_valid;
    // Expiry fires in the RD_TIMEOUT-th silent RD_WAIT cycle; a response in that cycle wins.
    assign expired = state == RD_WAIT && !mem_resp_valid && cnt == CNT_W'(RD_TIMEOUT - 1);
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = (grant_ld || grant_st) ? REQ : IDLE;
            REQ:     state_nxt = !mem_req_ready ? REQ : (mem_req_we ? IDLE : RD_WAIT);
            RD_WAIT: state_nxt = (resp_hit || expired) ? IDLE : RD_WAIT;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            last_st       <= 1'b1;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            rob_q         <= '0;
            cnt           <= '0;
            ld_resp_valid <= 1'b0;
            ld_resp_rob   <= '0;
            ld_resp_data  <= '0;
            timeout_err   <= 1'b0;
        end else begin
            ld_resp_valid <= resp_hit || expired;
            if (resp_hit) begin
                ld_resp_rob  <= rob_q;
                ld_resp_data <= mem_resp_data;
            end else if (expired) begin
                ld_resp_rob  <= rob_q;
                ld_resp_data <= '0;
                timeout_err  <= 1'b1;
            end
            if (ld_req_ready) begin
                last_st      <= 1'b0;
                mem_req_we   <= 1'b0;
                mem_req_addr <= ld_req_addr;
                rob_q        <= ld_req_rob;
            end
            if (st_req_ready) begin
                last_st       <= 1'b1;
                mem_req_we    <= 1'b1;
                mem_req_addr  <= st_req_addr;
                mem_req_wdata <= st_req_data;
            end
            if (state == REQ && mem_req_ready) cnt <= '0;
            else if (state == RD_WAIT && !mem_resp_valid) cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_lsu_mem_arb.sv
// tb_lsu_mem_arb: directed self-checking bench for lsu_mem_arb
module tb_lsu_mem_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic        ld_req_valid, ld_req_ready;
    logic [31:0] ld_req_addr;
    logic [5:0]  ld_req_rob;
    logic        ld_resp_valid;
    logic [5:0]  ld_resp_rob;
    logic [31:0] ld_resp_data;
    logic        st_req_valid, st_req_ready;
    logic [31:0] st_req_addr, st_req_data;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        busy, timeout_err;
    int chk = 0;
    int err = 0;

    lsu_mem_arb #(.RD_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready),
        .ld_req_addr(ld_req_addr), .ld_req_rob(ld_req_rob),
        .ld_resp_valid(ld_resp_valid), .ld_resp_rob(ld_resp_rob), .ld_resp_data(ld_resp_data),
        .st_req_valid(st_req_valid), .st_req_ready(st_req_ready),
        .st_req_addr(st_req_addr), .st_req_data(st_req_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        ld_req_valid = 1'b0;
        st_req_valid = 1'b0;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic start_load(input logic [31:0] a, input logic [5:0] r);
        ld_req_addr = a;
        ld_req_rob = r;
        ld_req_valid = 1'b1;
        mem_req_ready = 1'b1;
        tick;
        ld_req_valid = 1'b0;
    endtask

    task automatic test_reset;
        ld_req_addr = 32'h0; ld_req_rob = 6'h0; st_req_addr = 32'h0; st_req_data = 32'h0;
        mem_resp_data = 32'h0;
        do_reset;
        #1;
        chk++; if (mem_req_valid !== 1'b0) begin err++; $display("FAIL rst_mem_req_valid: got %b exp 0", mem_req_valid); end
        chk++; if (mem_req_we !== 1'b0) begin err++; $display("FAIL rst_mem_req_we: got %b exp 0", mem_req_we); end
        chk++; if (mem_req_addr !== 32'h0) begin err++; $display("FAIL rst_mem_req_addr: got %h exp 0", mem_req_addr); end
        chk++; if (mem_req_wdata !== 32'h0) begin err++; $display("FAIL rst_mem_req_wdata: got %h exp 0", mem_req_wdata); end
        chk++; if (ld_resp_valid !== 1'b0) begin err++; $display("FAIL rst_ld_resp_valid: got %b exp 0", ld_resp_valid); end
        chk++; if (ld_resp_rob !== 6'h0) begin err++; $display("FAIL rst_ld_resp_rob: got %h exp 0", ld_resp_rob); end
        chk++; if (ld_resp_data !== 32'h0) begin err++; $display("FAIL rst_ld_resp_data: got %h exp 0", ld_resp_data); end
        chk++; if (busy !== 1'b0) begin err++; $display("FAIL rst_busy: got %b exp 0", busy); end
        chk++; if (timeout_err !== 1'b0) begin err++; $display("FAIL rst_timeout_err: got %b exp 0", timeout_err); end
        chk++; if ({ld_req_ready, st_req_ready} !== 2'b00) begin err++; $display("FAIL rst_readies: got %b exp 00", {ld_req_ready, st_req_ready}); end
    endtask

    task automatic test_lone_load;
        ld_req_addr = 32'h100; ld_req_rob = 6'd5; ld_req_valid = 1'b1; mem_req_ready = 1'b1;
        #1;
        chk++; if (ld_req_ready !== 1'b1) begin err++; $display("FAIL lone_ld_ready: got %b exp 1", ld_req_ready); end
        tick;
        ld_req_valid = 1'b0;
        chk++; if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b0 || mem_req_addr !== 32'h100) begin
            err++; $display("FAIL lone_ld_mem_req: got v=%b we=%b a=%h exp v=1 we=0 a=100", mem_req_valid, mem_req_we, mem_req_addr);
        end
        tick;
        mem_resp_valid = 1'b1; mem_resp_data = 32'hDEADBEEF;
        chk++; if (ld_resp_valid !== 1'b0) begin err++; $display("FAIL lone_ld_early_resp: got %b exp 0", ld_resp_valid); end
        tick;
        mem_resp_valid = 1'b0;
        chk++; if (ld_resp_valid !== 1'b1 || ld_resp_rob !== 6'd5 || ld_resp_data !== 32'hDEADBEEF) begin
            err++; $display("FAIL lone_ld_resp: got v=%b rob=%0d d=%h exp v=1 rob=5 d=deadbeef", ld_resp_valid, ld_resp_rob, ld_resp_data);
        end
        tick;
        chk++; if (ld_resp_valid !== 1'b0 || ld_resp_rob !== 6'd5 || ld_resp_data !== 32'hDEADBEEF || busy !== 1'b0) begin
            err++; $display("FAIL lone_ld_hold: got v=%b rob=%0d d=%h busy=%b exp v=0 rob=5 d=deadbeef busy=0", ld_resp_valid, ld_resp_rob, ld_resp_data, busy);
        end
    endtask

    task automatic test_round_robin;
        logic exp_st;
        do_reset;
        ld_req_addr = 32'h10; st_req_addr = 32'h20; st_req_data = 32'h55AA;
        ld_req_valid = 1'b1; st_req_valid = 1'b1; mem_req_ready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            exp_st = (g % 2) == 1;
            ld_req_rob = 6'(g + 10);
            #1;
            chk++; if (st_req_ready !== exp_st || ld_req_ready !== !exp_st) begin
                err++; $display("FAIL rr_grant%0d: got ld=%b st=%b exp st=%b", g, ld_req_ready, st_req_ready, exp_st);
            end
            tick;
            chk++; if (mem_req_valid !== 1'b1 || mem_req_we !== exp_st || mem_req_addr !== (exp_st ? 32'h20 : 32'h10)) begin
                err++; $display("FAIL rr_mem%0d: got v=%b we=%b a=%h exp we=%b", g, mem_req_valid, mem_req_we, mem_req_addr, exp_st);
            end
            chk++; if ({ld_req_ready, st_req_ready} !== 2'b00) begin
                err++; $display("FAIL rr_busy_ready%0d: got %b exp 00", g, {ld_req_ready, st_req_ready});
            end
            tick;
            if (!exp_st) begin
                mem_resp_valid = 1'b1; mem_resp_data = 32'hA0 + g;
                tick;
                mem_resp_valid = 1'b0;
                chk++; if (ld_resp_valid !== 1'b1 || ld_resp_rob !== 6'(g + 10) || ld_resp_data !== 32'hA0 + g) begin
                    err++; $display("FAIL rr_resp%0d: got v=%b rob=%0d d=%h", g, ld_resp_valid, ld_resp_rob, ld_resp_data);
                end
            end
        end
        ld_req_valid = 1'b0; st_req_valid = 1'b0;
        tick;
    endtask

    task automatic test_conflict;
        do_reset;
        ld_req_addr = 32'h40; ld_req_rob = 6'd7; st_req_addr = 32'h40; st_req_data = 32'hCAFE0001;
        ld_req_valid = 1'b1; st_req_valid = 1'b1; mem_req_ready = 1'b1;
        #1;
        chk++; if (st_req_ready !== 1'b1 || ld_req_ready !== 1'b0) begin
            err++; $display("FAIL conflict_grant: got ld=%b st=%b exp ld=0 st=1", ld_req_ready, st_req_ready);
        end
        tick;
        st_req_valid = 1'b0;
        chk++; if (mem_req_we !== 1'b1 || mem_req_addr !== 32'h40 || mem_req_wdata !== 32'hCAFE0001) begin
            err++; $display("FAIL conflict_store: got we=%b a=%h d=%h exp we=1 a=40 d=cafe0001", mem_req_we, mem_req_addr, mem_req_wdata);
        end
        tick;
        #1;
        chk++; if (ld_req_ready !== 1'b1) begin err++; $display("FAIL conflict_load_next: got %b exp 1", ld_req_ready); end
        tick;
        ld_req_valid = 1'b0;
        chk++; if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b0 || mem_req_addr !== 32'h40) begin
            err++; $display("FAIL conflict_load_mem: got v=%b we=%b a=%h exp v=1 we=0 a=40", mem_req_valid, mem_req_we, mem_req_addr);
        end
        tick;
        mem_resp_valid = 1'b1; mem_resp_data = 32'h12345678;
        tick;
        mem_resp_valid = 1'b0;
        chk++; if (ld_resp_valid !== 1'b1 || ld_resp_rob !== 6'd7 || ld_resp_data !== 32'h12345678) begin
            err++; $display("FAIL conflict_load_resp: got v=%b rob=%0d d=%h", ld_resp_valid, ld_resp_rob, ld_resp_data);
        end
        tick;
    endtask

    task automatic test_stall;
        st_req_addr = 32'h80; st_req_data = 32'h00001234; st_req_valid = 1'b1; mem_req_ready = 1'b0;
        tick;
        st_req_addr = 32'h84; st_req_data = 32'hFFFF0000;
        ld_req_addr = 32'h88; ld_req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk++; if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b1 || mem_req_addr !== 32'h80 || mem_req_wdata !== 32'h00001234) begin
                err++; $display("FAIL stall_hold%0d: got v=%b we=%b a=%h d=%h", i, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata);
            end
            chk++; if ({ld_req_ready, st_req_ready} !== 2'b00) begin
                err++; $display("FAIL stall_ready%0d: got %b exp 00", i, {ld_req_ready, st_req_ready});
            end
            tick;
        end
        mem_req_ready = 1'b1; ld_req_valid = 1'b0; st_req_valid = 1'b0;
        tick;
        chk++; if (busy !== 1'b0 || mem_req_valid !== 1'b0) begin
            err++; $display("FAIL stall_release: got busy=%b v=%b exp 0 0", busy, mem_req_valid);
        end
    endtask

    task automatic test_resp_beats_timeout;
        do_reset;
        start_load(32'h300, 6'd3);
        tick;
        tick;
        tick;
        tick;
        chk++; if (ld_resp_valid !== 1'b0 || busy !== 1'b1) begin
            err++; $display("FAIL race_pre: got v=%b busy=%b exp v=0 busy=1", ld_resp_valid, busy);
        end
        mem_resp_valid = 1'b1; mem_resp_data = 32'h0BADF00D;
        tick;
        mem_resp_valid = 1'b0;
        chk++; if (ld_resp_valid !== 1'b1 || ld_resp_rob !== 6'd3 || ld_resp_data !== 32'h0BADF00D || timeout_err !== 1'b0) begin
            err++; $display("FAIL race_resp: got v=%b rob=%0d d=%h terr=%b exp 1 3 0badf00d 0", ld_resp_valid, ld_resp_rob, ld_resp_data, timeout_err);
        end
        tick;
    endtask

    task automatic test_timeout;
        int n;
        chk++; if (timeout_err !== 1'b0) begin err++; $display("FAIL to_pre: got %b exp 0", timeout_err); end
        start_load(32'h200, 6'd9);
        tick;
        n = 0;
        while (ld_resp_valid !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
        chk++; if (n !== 4) begin err++; $display("FAIL to_latency: got %0d cycles exp 4", n); end
        chk++; if (ld_resp_valid !== 1'b1 || ld_resp_rob !== 6'd9 || ld_resp_data !== 32'h0 || timeout_err !== 1'b1) begin
            err++; $display("FAIL to_resp: got v=%b rob=%0d d=%h terr=%b exp 1 9 0 1", ld_resp_valid, ld_resp_rob, ld_resp_data, timeout_err);
        end
        tick;
        tick;
        chk++; if (timeout_err !== 1'b1 || busy !== 1'b0 || ld_resp_valid !== 1'b0) begin
            err++; $display("FAIL to_sticky: got terr=%b busy=%b v=%b exp 1 0 0", timeout_err, busy, ld_resp_valid);
        end
        do_reset;
        chk++; if (timeout_err !== 1'b0) begin err++; $display("FAIL to_cleared: got %b exp 0", timeout_err); end
    endtask

    task automatic test_reset_in_flight;
        start_load(32'h400, 6'd12);
        tick;
        chk++; if (busy !== 1'b1) begin err++; $display("FAIL rif_busy: got %b exp 1", busy); end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk++; if (busy !== 1'b0 || ld_resp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
            err++; $display("FAIL rif_after_rst: got busy=%b v=%b mv=%b exp 0 0 0", busy, ld_resp_valid, mem_req_valid);
        end
        mem_resp_valid = 1'b1; mem_resp_data = 32'h77;
        tick;
        mem_resp_valid = 1'b0;
        chk++; if (ld_resp_valid !== 1'b0 || ld_resp_data !== 32'h0) begin
            err++; $display("FAIL rif_late_resp: got v=%b d=%h exp 0 0", ld_resp_valid, ld_resp_data);
        end
        tick;
        chk++; if (ld_resp_valid !== 1'b0 || busy !== 1'b0) begin
            err++; $display("FAIL rif_quiet: got v=%b busy=%b exp 0 0", ld_resp_valid, busy);
        end
    endtask

    initial begin
        test_reset;
        test_lone_load;
        test_round_robin;
        test_conflict;
        test_stall;
        test_timeout;
        test_resp_beats_timeout;
        test_reset_in_flight;
        $display("Simulation finished: %0d checks, %0d errors", chk, err);
        $finish;
    end
endmodule
